// File: rtl/cpu_phase_controller.sv
// cpu_phase_controller: 8-phase fetch/execute strobe sequencer for the 8-bit RISC CPU.
// Optional instruction-retired counter (icount port) is built when CTRL_ICNT_EN is defined.
module cpu_phase_controller #(
  parameter int OPW    = 3,
  parameter int ICNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              sel,
  output logic              rd,
  output logic              wr,
  output logic              ld_ir,
  output logic              ld_ac,
  output logic              data_e,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              halt,
  output logic [2:0]        phase
`ifdef CTRL_ICNT_EN
  ,
  output logic [ICNT_W-1:0] icount
`endif
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  phase_t  r_phase;
  logic    r_halted;
  opcode_t w_op;
  logic    w_aluop;
  logic    w_advance;

  assign w_op      = opcode_t'(opcode);
  assign w_aluop   = (w_op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});
  assign w_advance = en && !r_halted;
  assign phase     = r_phase;

  // Halting is decided on the edge leaving OP_ADDR, so the phase parks at OP_FETCH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else if (w_advance) begin
      if (r_phase == PH_OP_ADDR && w_op == OP_HLT) begin
        r_halted <= 1'b1;
      end
      r_phase <= phase_t'(r_phase + 3'd1);
    end
  end

`ifdef CTRL_ICNT_EN
  logic [ICNT_W-1:0] r_icount;

  // HLT never reaches STORE, so halting instructions are never counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_icount <= '0;
    end else if (w_advance && r_phase == PH_STORE) begin
      r_icount <= r_icount + 1'b1;
    end
  end

  assign icount = r_icount;
`endif

  // Strobes decode straight from the phase register; reset forcing phase 0 yields sel=1 at once.
  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    data_e  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    halt    = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          pc_inc = 1'b1;
          halt   = (w_op == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = w_aluop;
        end
        PH_ALU_OP: begin
          rd      = w_aluop;
          pc_inc  = (w_op == OP_SKZ) && zero;
          pc_load = (w_op == OP_JMP);
          data_e  = (w_op == OP_STO);
        end
        PH_STORE: begin
          rd      = w_aluop;
          ld_ac   = w_aluop;
          pc_load = (w_op == OP_JMP);
          pc_inc  = (w_op == OP_JMP);
          data_e  = (w_op == OP_STO);
          wr      = (w_op == OP_STO);
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

  // Structural invariants of the strobe decode.
  always_ff @(posedge clock) begin
    assert (OPW == 3 && ICNT_W > 0);
    if (!reset) begin
      assert (!(wr && rd));
      assert (!wr || r_phase == PH_STORE);
      assert (!data_e || r_phase == PH_ALU_OP || r_phase == PH_STORE);
    end
  end

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Bench for cpu_phase_controller: vector table, corner-case sequences, random run vs mask model.
// Define CTRL_ICNT_EN to also exercise the retired-instruction counter (built with ICNT_W=4).
module tb_cpu_phase_controller;

  localparam int TB_ICNT_W = 4;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  // Output vector order: {sel, rd, wr, ld_ir, ld_ac, data_e, pc_inc, pc_load, halt}
  localparam logic [8:0] O_SEL  = 9'h100, O_RD = 9'h080, O_WR  = 9'h040;
  localparam logic [8:0] O_LDIR = 9'h020, O_LDAC = 9'h010, O_DE = 9'h008;
  localparam logic [8:0] O_INC  = 9'h004, O_LD = 9'h002, O_HALT = 9'h001;

  logic       clock;
  logic       reset;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, data_e, pc_inc, pc_load, halt;
  logic [2:0] phase;
  logic [8:0] outs;
`ifdef CTRL_ICNT_EN
  logic [TB_ICNT_W-1:0] icount;
`endif

  assign outs = {sel, rd, wr, ld_ir, ld_ac, data_e, pc_inc, pc_load, halt};

  cpu_phase_controller #(.OPW(3), .ICNT_W(TB_ICNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .opcode  (opcode),
    .zero    (zero),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ld_ir   (ld_ir),
    .ld_ac   (ld_ac),
    .data_e  (data_e),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .halt    (halt),
    .phase   (phase)
`ifdef CTRL_ICNT_EN
    ,
    .icount  (icount)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Per-opcode phase masks: bit i of a mask means the strobe is high in phase i.
  int                   m_phase;
  bit                   m_halted;
  logic [TB_ICNT_W-1:0] m_icount;

  function automatic logic [8:0] model_out(input int ph, input bit halted,
                                           input logic [2:0] op, input logic z);
    bit         alu;
    logic [7:0] k_sel, k_rd, k_wr, k_ldir, k_ldac, k_de, k_inc, k_ld, k_halt;
    alu    = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    k_sel  = 8'h0F;
    k_rd   = 8'h0E | (alu ? 8'hE0 : 8'h00);
    k_wr   = (op == STO) ? 8'h80 : 8'h00;
    k_ldir = 8'h0C;
    k_ldac = alu ? 8'h80 : 8'h00;
    k_de   = (op == STO) ? 8'hC0 : 8'h00;
    k_inc  = 8'h10 | ((op == JMP) ? 8'h80 : 8'h00) | ((op == SKZ && z) ? 8'h40 : 8'h00);
    k_ld   = (op == JMP) ? 8'hC0 : 8'h00;
    k_halt = (op == HLT) ? 8'h10 : 8'h00;
    if (halted) return O_HALT;
    return {k_sel[ph], k_rd[ph], k_wr[ph], k_ldir[ph], k_ldac[ph],
            k_de[ph], k_inc[ph], k_ld[ph], k_halt[ph]};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_halted = 1'b0;
    m_icount = '0;
  endtask

  task automatic model_step();
    if (en && !m_halted) begin
      if (m_phase == 4 && opcode == HLT) m_halted = 1'b1;
      if (m_phase == 7) m_icount = m_icount + 1'b1;
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at a falling edge with inputs already applied.
  task automatic step_check(input string name, input logic [2:0] exp_ph, input logic [8:0] exp_out);
    #1 check(name, {phase, outs}, {exp_ph, exp_out});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, released well away from the rising edge.
  task automatic do_reset(input string name);
    #2 reset = 1'b1;
    #1 check(name, {phase, outs}, {3'd0, O_SEL});
`ifdef CTRL_ICNT_EN
    check({name, "_icount"}, icount, 0);
`endif
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    model_reset();
  endtask

  function automatic logic [8:0] instr_out(input int ph, input logic [8:0] p5,
                                           input logic [8:0] p6, input logic [8:0] p7);
    case (ph)
      0:       return O_SEL;
      1:       return O_SEL | O_RD;
      2, 3:    return O_SEL | O_RD | O_LDIR;
      4:       return O_INC;
      5:       return p5;
      6:       return p6;
      default: return p7;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       en;
    logic [2:0] ph;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_instr(input logic [2:0] op, input logic z,
                           input logic [8:0] p5, input logic [8:0] p6, input logic [8:0] p7);
    for (int p = 0; p < 8; p++) vecs.push_back('{op, z, 1'b1, 3'(p), instr_out(p, p5, p6, p7)});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    opcode = ADD;
    zero   = 1'b0;
    model_reset();

    #2 check("reset_state", {phase, outs}, {3'd0, O_SEL});
    @(negedge clock);
    reset = 1'b0;

    add_instr(ADD, 1'b0, O_RD, O_RD, O_RD | O_LDAC);
    vecs.push_back('{ADD, 1'b0, 1'b0, 3'd0, O_SEL});
    vecs.push_back('{ADD, 1'b1, 1'b0, 3'd0, O_SEL});
    add_instr(SKZ, 1'b1, 9'h000, O_INC, 9'h000);
    add_instr(SKZ, 1'b0, 9'h000, 9'h000, 9'h000);
    add_instr(STO, 1'b0, 9'h000, O_DE, O_DE | O_WR);
    add_instr(JMP, 1'b1, 9'h000, O_LD, O_INC | O_LD);
    add_instr(LDA, 1'b1, O_RD, O_RD, O_RD | O_LDAC);
    add_instr(XOR, 1'b0, O_RD, O_RD, O_RD | O_LDAC);
    add_instr(AND, 1'b1, O_RD, O_RD, O_RD | O_LDAC);

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      en     = vecs[i].en;
      step_check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].exp);
    end

    // Reset in the middle of STO's ALU_OP phase abandons the store.
    do_reset("sto_pre_reset");
    opcode = STO;
    en     = 1'b1;
    for (int p = 0; p < 6; p++) step_check("sto_run", 3'(p), instr_out(p, 9'h000, O_DE, O_DE | O_WR));
    #1 check("sto_p6", {phase, outs}, {3'd6, O_DE});
    #2 reset = 1'b1;
    #1 check("sto_mid_reset", {phase, outs}, {3'd0, O_SEL});
    @(posedge clock);
    #1 check("sto_reset_hold_wr", wr, 0);
    #1 reset = 1'b0;
    @(negedge clock);
    opcode = ADD;
    for (int p = 0; p < 8; p++) begin
      #1 check("after_reset_ldir", ld_ir, (p == 2 || p == 3));
      check("after_reset_wr", wr, 0);
      check("after_reset_phase", phase, p);
      tick();
    end

    // HLT parks at phase 5 and ignores en until reset.
    do_reset("hlt_pre_reset");
    opcode = HLT;
    en     = 1'b1;
    for (int p = 0; p < 4; p++) step_check("hlt_fetch", 3'(p), instr_out(p, 9'h0, 9'h0, 9'h0));
    step_check("hlt_op_addr", 3'd4, O_INC | O_HALT);
    for (int i = 0; i < 20; i++) begin
      en     = 1'($urandom_range(0, 1));
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      step_check("hlt_frozen", 3'd5, O_HALT);
    end
    do_reset("hlt_reset");
    opcode = ADD;
    en     = 1'b0;
    for (int i = 0; i < 3; i++) step_check("en_low_hold", 3'd0, O_SEL);
    en = 1'b1;
    step_check("resume_p0", 3'd0, O_SEL);
    #1 check("resume_p1", {phase, outs}, {3'd1, O_SEL | O_RD});

`ifdef CTRL_ICNT_EN
    @(negedge clock);
    do_reset("icnt_reset");
    opcode = ADD;
    en     = 1'b1;
    repeat (17 * 8) tick();
    #1 check("icnt_wrap", icount, 1);
    check("icnt_wrap_phase", phase, 0);
`endif

    // Randomised run against the mask model.
    @(negedge clock);
    do_reset("rand_reset0");
    begin
      int halted_cycles = 0;
      for (int c = 0; c < 3000; c++) begin
        if (m_phase <= 2 || m_halted) opcode = 3'($urandom_range(0, 7));
        zero = 1'($urandom_range(0, 1));
        en   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0 || halted_cycles > 8) begin
          do_reset("rand_reset");
          halted_cycles = 0;
        end else begin
          #1 check("rand", {phase, outs}, {3'(m_phase), model_out(m_phase, m_halted, opcode, zero)});
`ifdef CTRL_ICNT_EN
          check("rand_icount", icount, m_icount);
`endif
          @(posedge clock);
          model_step();
          @(negedge clock);
          if (m_halted) halted_cycles++;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
